// File: rtl/data_to_segments_pkg.sv
// Shared types and helpers for the binary-to-7-segment display path.
package data_to_segments_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Active-high pattern with no segment lit.
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // Active-high {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'd0:    pat = 7'b011_1111;
      4'd1:    pat = 7'b000_0110;
      4'd2:    pat = 7'b101_1011;
      4'd3:    pat = 7'b100_1111;
      4'd4:    pat = 7'b110_0110;
      4'd5:    pat = 7'b110_1101;
      4'd6:    pat = 7'b111_1101;
      4'd7:    pat = 7'b000_0111;
      4'd8:    pat = 7'b111_1111;
      4'd9:    pat = 7'b110_1111;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // True when `digits` decimal digits can hold every value of a `size`-bit magnitude.
  function automatic bit digits_ok(input int size, input int digits);
    longint unsigned p10;
    longint unsigned p2;
    p10 = 1;
    p2  = 1;
    for (int i = 0; i < digits; i++) p10 = p10 * 10;
    for (int i = 0; i < size; i++)   p2  = p2 * 2;
    return p10 > p2;
  endfunction

endpackage

// File: rtl/data_to_segments_bin2bcd.sv
// Serial double-dabble converter: one magnitude bit per clock, add-3 then shift.
module bin2bcd_serial
  import data_to_segments_pkg::*;
#(
  parameter int Size   = 5,
  parameter int Digits = 2
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  start_i,
  input  logic [Size-1:0]       mag_i,
  output logic                  done_o,
  output logic [4*Digits-1:0]   bcd_o
);

  localparam int CW = $clog2(Size + 1);

  logic [Size-1:0]     mag_q,  mag_d;
  logic [4*Digits-1:0] bcd_q,  bcd_d;
  logic [CW-1:0]       cnt_q,  cnt_d;
  logic [4*Digits-1:0] bcd_adj;

  // Add-3 correction on every nibble >= 5, then shift the magnitude MSB into the BCD.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    bcd_adj = bcd_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < Digits; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    if (start_i) begin
      mag_d = mag_i;
      bcd_d = '0;
      cnt_d = CW'(Size);
    end else if (cnt_q != '0) begin
      bcd_d = {bcd_adj[4*Digits-2:0], mag_q[Size-1]};
      mag_d = {mag_q[Size-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Converter state registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      mag_q <= mag_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  // High during the cycle whose closing edge performs the final shift.
  assign done_o = (cnt_q == CW'(1)) && !start_i;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/data_to_segments.sv
// Converts the generator's value to decimal and drives registered 7-segment digits
// plus a minus indicator; the display only changes on a completed conversion.
module data_to_segments
  import data_to_segments_pkg::*;
#(
  parameter int    Size         = 5,
  parameter string Signed       = "No",
  parameter int    Digits       = 2,
  parameter string SegActiveLow = "Yes",
  parameter string BlankZeros   = "Yes"
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [Size-1:0]       Data,
  input  logic                  SigneBit,
  output logic [7*Digits-1:0]   Segments,
  output logic                  Minus,
  output logic                  Busy,
  output logic                  Valid
);

  if (!digits_ok(Size, Digits)) begin : g_bad_digits
    $error("Digits=%0d too small for Size=%0d", Digits, Size);
  end

  localparam bit IS_SIGNED = (Signed == "Yes");
  localparam bit SEG_LOW   = (SegActiveLow == "Yes");
  localparam bit BLANK_LZ  = (BlankZeros == "Yes");

  state_e              state_q, state_d;
  logic [Size:0]       snap_q;
  logic                dirty_q;
  logic                neg_q;
  logic                capture, start;
  logic [Size-1:0]     data_s, mag_c;
  logic                neg_c;
  logic [4*Digits-1:0] bcd;
  logic                conv_done;
  logic [7*Digits-1:0] seg_q, seg_d;
  logic                minus_q, minus_d;

  // Magnitude and sign from the captured snapshot.
  assign data_s = snap_q[Size:1];
  assign neg_c  = IS_SIGNED ? data_s[Size-1] : snap_q[0];
  assign mag_c  = (IS_SIGNED && neg_c) ? -data_s : data_s;

  // Next-state logic: restart whenever the inputs differ from the last converted snapshot.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: if (dirty_q || ({Data, SigneBit} != snap_q)) begin
        capture = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        start   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (conv_done) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, input snapshot and latched sign.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      dirty_q <= 1'b1;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        snap_q  <= {Data, SigneBit};
        dirty_q <= 1'b0;
      end
      if (start) neg_q <= neg_c;
    end
  end

  bin2bcd_serial #(.Size(Size), .Digits(Digits)) u_bin2bcd (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .start_i (start),
    .mag_i   (mag_c),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // Digit patterns with leading-zero blanking, minus suppressed for zero, polarity applied.
  always_comb begin
    logic       seen;
    logic [3:0] nib;
    logic [6:0] pat;
    logic       lit;
    seg_d = '0;
    seen  = 1'b0;
    for (int k = Digits - 1; k >= 0; k--) begin
      nib = bcd[4*k +: 4];
      if (nib != 4'd0) seen = 1'b1;
      pat = (BLANK_LZ && (k > 0) && !seen) ? SEG_BLANK : seg7(nib);
      seg_d[7*k +: 7] = SEG_LOW ? ~pat : pat;
    end
    lit     = neg_q && (bcd != '0);
    minus_d = SEG_LOW ? ~lit : lit;
  end

  // Display registers load only at the end of a conversion.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      seg_q   <= {(7*Digits){SEG_LOW}};
      minus_q <= SEG_LOW;
    end else if (state_q == DONE) begin
      seg_q   <= seg_d;
      minus_q <= minus_d;
    end
  end

  assign Segments = seg_q;
  assign Minus    = minus_q;
  assign Busy     = (state_q == LOAD) || (state_q == SHIFT);
  assign Valid    = (state_q == DONE);

endmodule

// File: tb/tb_data_to_segments.sv
// Directed bench: an unsigned-mode and a signed-mode instance share clock, reset and inputs.
module tb_data_to_segments;

  // Active-low digit patterns {g..a}
  localparam logic [6:0] D0 = 7'b100_0000;
  localparam logic [6:0] D1 = 7'b111_1001;
  localparam logic [6:0] D2 = 7'b010_0100;
  localparam logic [6:0] D3 = 7'b011_0000;
  localparam logic [6:0] D6 = 7'b000_0010;
  localparam logic [6:0] D7 = 7'b111_1000;
  localparam logic [6:0] D9 = 7'b001_0000;
  localparam logic [6:0] DB = 7'b111_1111;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [4:0]  Data;
  logic        SigneBit;
  logic [13:0] seg_u, seg_s;
  logic        minus_u, minus_s, busy_u, busy_s, valid_u, valid_s;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, busy_n, k;

  always #5 Clock = ~Clock;

  data_to_segments #(.Size(5), .Signed("No"), .Digits(2), .SegActiveLow("Yes"), .BlankZeros("Yes")) dut_u (
    .Clock(Clock), .Reset_n(Reset_n), .Data(Data), .SigneBit(SigneBit),
    .Segments(seg_u), .Minus(minus_u), .Busy(busy_u), .Valid(valid_u));

  data_to_segments #(.Size(5), .Signed("Yes"), .Digits(2), .SegActiveLow("Yes"), .BlankZeros("Yes")) dut_s (
    .Clock(Clock), .Reset_n(Reset_n), .Data(Data), .SigneBit(SigneBit),
    .Segments(seg_s), .Minus(minus_s), .Busy(busy_s), .Valid(valid_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for Valid, counting negedges and Busy cycles, then one more
  // negedge so the registered display is visible.
  task automatic wait_valid(input string tag, output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      cycles++;
      if (busy_u) busy_cycles++;
      if (valid_u) break;
    end
    check({tag, "_valid_seen"}, 32'(valid_u), 32'd1);
    @(negedge Clock);
  endtask

  initial begin
    // 1. Reset state, then first conversion of 0
    Reset_n  = 1'b0;
    Data     = 5'd0;
    SigneBit = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_seg",   32'(seg_u),   32'h3FFF);
    check("rst_minus", 32'(minus_u), 32'd1);
    check("rst_busy",  32'(busy_u),  32'd0);
    check("rst_valid", 32'(valid_u), 32'd0);
    Reset_n = 1'b1;
    wait_valid("zero", lat, busy_n);
    check("zero_latency", 32'(lat),     32'd7);
    check("zero_seg",     32'(seg_u),   32'({DB, D0}));
    check("zero_minus",   32'(minus_u), 32'd1);

    // 2. Data=31: "31" unsigned, "-1" signed; Busy exactly 6 cycles
    Data = 5'd31;
    wait_valid("d31", lat, busy_n);
    check("d31_latency", 32'(lat),     32'd7);
    check("d31_busy",    32'(busy_n),  32'd6);
    check("d31_seg",     32'(seg_u),   32'({D3, D1}));
    check("d31_minus",   32'(minus_u), 32'd1);
    check("d31s_seg",    32'(seg_s),   32'({DB, D1}));
    check("d31s_minus",  32'(minus_s), 32'd0);

    // 3. Magnitude with sign bit, then negative zero
    Data = 5'd12; SigneBit = 1'b1;
    wait_valid("d12", lat, busy_n);
    check("d12_seg",    32'(seg_u),   32'({D1, D2}));
    check("d12_minus",  32'(minus_u), 32'd0);
    check("d12s_seg",   32'(seg_s),   32'({D1, D2}));
    check("d12s_minus", 32'(minus_s), 32'd1);
    Data = 5'd0;
    wait_valid("negz", lat, busy_n);
    check("negz_seg",   32'(seg_u),   32'({DB, D0}));
    check("negz_minus", 32'(minus_u), 32'd1);

    // 4. Two's complement extremes on the signed instance
    Data = 5'b10000; SigneBit = 1'b0;
    wait_valid("m16", lat, busy_n);
    check("m16s_seg",   32'(seg_s),   32'({D1, D6}));
    check("m16s_minus", 32'(minus_s), 32'd0);
    check("p16_seg",    32'(seg_u),   32'({D1, D6}));
    check("p16_minus",  32'(minus_u), 32'd1);
    Data = 5'b11111;
    wait_valid("m1", lat, busy_n);
    check("m1s_seg",   32'(seg_s),   32'({DB, D1}));
    check("m1s_minus", 32'(minus_s), 32'd0);

    // 5. Input change during the 3rd SHIFT cycle is deferred to a second conversion
    Data = 5'd7;
    repeat (4) @(negedge Clock);
    check("chg_busy", 32'(busy_u), 32'd1);
    Data = 5'd9;
    wait_valid("d7", lat, busy_n);
    check("d7_latency", 32'(lat + 4), 32'd7);
    check("d7_seg",     32'(seg_u),   32'({DB, D7}));
    k = 0;
    while (!busy_u && k < 3) begin
      @(negedge Clock);
      k++;
    end
    check("restart_within_2", 32'(busy_u && k <= 2), 32'd1);
    wait_valid("d9", lat, busy_n);
    check("d9_seg", 32'(seg_u), 32'({DB, D9}));

    // 6. Asynchronous reset mid-SHIFT, then fresh conversion of the current Data
    Data = 5'd25;
    repeat (3) @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_seg",   32'(seg_u),   32'h3FFF);
    check("arst_minus", 32'(minus_u), 32'd1);
    check("arst_busy",  32'(busy_u),  32'd0);
    check("arst_valid", 32'(valid_u), 32'd0);
    Data = 5'd20;
    @(negedge Clock);
    Reset_n = 1'b1;
    wait_valid("d20", lat, busy_n);
    check("d20_latency", 32'(lat),     32'd7);
    check("d20_seg",     32'(seg_u),   32'({D2, D0}));
    check("d20_minus",   32'(minus_u), 32'd1);
    check("d20s_seg",    32'(seg_s),   32'({D1, D2}));
    check("d20s_minus",  32'(minus_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
